// File: rtl/serial_reg_loader_if.sv
// Purpose: bundles the serial line, button and command outputs of serial_reg_loader.
// Latency: none, wires only.
// Backpressure: none; every output is a pulse or a level the consumer samples each cycle.
interface serial_reg_loader_if;
  logic       rx;
  logic       btn;
  logic       ld;
  logic [7:0] data;
  logic       inc;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    output btn,
    input  ld,
    input  data,
    input  inc,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    input  btn,
    output ld,
    output data,
    output inc,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/serial_reg_loader.sv
// Purpose: serial byte receiver plus debounced button, emitting ld/data and inc commands.
// Latency: ld one cycle after the stop-bit sample; inc on the debounced rise, or one cycle later if it collides with ld.
// Backpressure: none; ld, inc and frame_err are single-cycle pulses that must be consumed when seen.
module serial_reg_loader #(
  parameter int CLKS_PER_BIT    = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input logic               clk,
  input logic               rst_n,
  serial_reg_loader_if.slave bus
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // synchronizer and edge-detect state
  logic rx_meta, rx_s, rx_prev;
  logic btn_meta, btn_s;
  logic rx_fall;

  // receive FSM state
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          ld_q, ld_d;
  logic          ferr_q, ferr_d;
  logic          busy_q;

  // debounce and inc arbitration state
  logic [DW-1:0] db_cnt_q;
  logic          db_lvl_q;
  logic          rise_q;
  logic          pend_q;

  // Two-flop synchronizers; rx idles high so it resets to 1, the button resets released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      rx_meta  <= bus.rx;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      btn_meta <= bus.btn;
      btn_s    <= btn_meta;
    end
  end

  // Only a true 1->0 transition starts a frame, so a line stuck low never retriggers.
  assign rx_fall = rx_prev & ~rx_s;

  // Receive FSM register stage; busy follows the next state so it is registered with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ld_q    <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ld_q    <= ld_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Receive FSM next-state: half-bit wait to centre on the start bit, then full-bit strides.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ld_d    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_fall) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          // a start bit that is already high again at its centre was a glitch
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d = shift_q;
            ld_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Debounce: a level change is accepted after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      db_lvl_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      if (btn_s == db_lvl_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_cnt_q <= '0;
        db_lvl_q <= ~db_lvl_q;
        // only the press (0->1) is a request; release is silent
        rise_q   <= ~db_lvl_q;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  // A request colliding with ld is deferred one cycle; ld is never two cycles wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= rise_q & ld_q;
    end
  end

  assign bus.ld        = ld_q;
  assign bus.data      = data_q;
  assign bus.inc       = (rise_q & ~ld_q) | pend_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/serial_reg_loader.md
Name: serial_reg_loader

Overview:
- Upstream command front-end for the 8-bit load/increment register.
- Receives bytes on an asynchronous serial line (start bit, 8 data bits LSB first, stop bit; idle high). Each good byte is presented on data with a one-cycle ld pulse.
- Debounces a push-button and turns each clean press into a one-cycle inc pulse.
- Never asserts ld and inc in the same cycle, so no increment is lost to the register's ld-over-inc priority.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; even, >= 4
DEBOUNCE_CYCLES, 1000, consecutive stable cycles needed to accept a button level change; >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
rx  input  1  asynchronous serial line, idle high
btn  input  1  asynchronous push-button, active high
ld  output  1  one-cycle pulse: data holds a newly received byte
data  output  8  last correctly framed byte
inc  output  1  one-cycle pulse per debounced button press
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high while the receive FSM is not IDLE

Behaviour:
- Reset: ld=0, inc=0, frame_err=0, busy=0, data=8'h00. FSM goes to IDLE, counters clear, pending-inc clears. rx synchronizer resets to 1; btn synchronizer and debounced level reset to 0.
- Synchronizers: rx and btn each pass through 2 flops. All logic below uses the synchronized signals (rx_s, btn_s).
- Start detection: IDLE leaves only on a falling edge of rx_s (previous 1, current 0). A line held low after a framing error does not retrigger.
- RX FSM states and transitions:
  - IDLE -> START on a falling edge of rx_s; bit counter cleared.
  - START: wait CLKS_PER_BIT/2 cycles, then sample rx_s. If 0 -> DATA with bit index 0. If 1 -> IDLE as a glitch; no error, no output.
  - DATA: sample rx_s every CLKS_PER_BIT cycles, shifting right with the new bit into the MSB. After the 8th sample -> STOP.
  - STOP: sample rx_s after CLKS_PER_BIT cycles.
    - Sample 1: data <= shift register, ld=1 in the next cycle, then IDLE.
    - Sample 0: frame_err=1 in the next cycle, data unchanged, no ld, then IDLE.
- Back-to-back frames: a start edge right after the stop sample is accepted. No extra idle time is required.
- busy = (state != IDLE), registered with the state.
- data changes only in the same cycle ld rises, and then holds.
- Debounce:
  - Counter runs while btn_s differs from the debounced level. It clears whenever btn_s equals the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A rising edge of the debounced level is an inc request. Release (falling edge) generates nothing.
- inc arbitration:
  - Request in a cycle with no ld: inc=1 in that cycle.
  - Request coinciding with ld: set pending; inc=1 in the following cycle (ld is a single-cycle pulse, so that cycle is always free).
  - At most one pending request. DEBOUNCE_CYCLES >= 2 guarantees no second request arrives first.
- Invariant: ld & inc never both 1 in any cycle.
- Reset mid-frame or mid-debounce: abort immediately to reset values, including data=8'h00 and any pending inc dropped.

Test Plan:
(CLKS_PER_BIT=16, DEBOUNCE_CYCLES=8)
1. Assert rst_n=0 with rx=1, btn=0, then release -> ld=inc=frame_err=busy=0, data=8'h00; stays so for 200 idle cycles.
2. Send frame 0xA5, then 0x3C immediately after the stop bit:
   - exactly one ld per frame, each 1 cycle wide;
   - data=8'hA5 at the first ld, 8'h3C at the second;
   - busy high from start detection until the stop sample;
   - frame_err never asserted.
3. Send 0x55 with the stop bit driven 0, then hold rx=0 for 100 cycles:
   - one frame_err pulse, no ld, data stays 8'h3C, busy=0 during the hold;
   - then rx=1 and send 0x0F -> ld with data=8'h0F.
4. Drive an rx low glitch of 4 cycles -> busy rises then returns 0; no ld, no frame_err, data unchanged.
5. Bounce btn high/low in 3-cycle pulses for 40 cycles -> no inc. Hold btn high 20 cycles -> exactly one inc pulse. Release, wait 20 cycles, press again -> one more inc.
6. Time a button press so its inc request lands in the same cycle as ld of frame 0x81 -> ld in cycle N with data=8'h81, inc in cycle N+1; never both high.
   Then assert rst_n=0 mid-DATA of the next frame -> busy=0, data=8'h00, no ld after release.
